// File: rtl/vram_arbiter.sv
// Single-port framebuffer RAM arbiter: scanout reads always win, pixel writes are queued
// in a small FIFO and drained into the RAM whenever scanout leaves the port free.
module vram_arbiter #(
  parameter int unsigned Waddr     = 19,
  parameter int unsigned Wdata     = 1,
  parameter int unsigned Depth     = 4,
  parameter int unsigned StarveMax = 1024
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       VREQ,
  input  logic [Waddr-1:0]           VADDR,
  output logic [Wdata-1:0]           VDATA,
  output logic                       VVALID,
  input  logic                       WVALID,
  input  logic [Waddr-1:0]           WADDR,
  input  logic [Wdata-1:0]           WDATA,
  output logic                       WREADY,
  output logic [Waddr-1:0]           MADDR,
  output logic                       MWE,
  output logic [Wdata-1:0]           MWDATA,
  input  logic [Wdata-1:0]           MRDATA,
  output logic [$clog2(Depth):0]     COUNT,
  output logic                       STARVE,
  input  logic                       CLR
);

  localparam int unsigned Pw = $clog2(Depth);
  localparam int unsigned Cw = $clog2(Depth) + 1;
  localparam int unsigned Sw = $clog2(StarveMax + 1);
  localparam logic [Cw-1:0] DepthC     = Cw'(Depth);
  localparam logic [Sw-1:0] StarveMaxC = Sw'(StarveMax);

  typedef enum logic [1:0] {GntIdle, GntRead, GntWrite} grant_e;

  grant_e grant;

  logic [Waddr-1:0] addr_mem [Depth];
  logic [Wdata-1:0] data_mem [Depth];

  logic [Pw-1:0] wr_ptr_q, wr_ptr_d;
  logic [Pw-1:0] rd_ptr_q, rd_ptr_d;
  logic [Cw-1:0] count_q, count_d;
  logic          vvalid_q;
  logic [Sw-1:0] starve_cnt_q, starve_cnt_d;
  logic          starve_q, starve_d;

  logic full, empty, push, pop;
  logic starve_cond, starve_set;

  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);

  // Fixed priority: scanout is hard real-time, the writer only gets leftover cycles.
  always_comb begin
    grant = GntIdle;
    if (VREQ) begin
      grant = GntRead;
    end else if (!empty && !RST) begin
      grant = GntWrite;
    end
  end

  assign MWE    = (grant == GntWrite);
  assign MADDR  = (grant == GntWrite) ? addr_mem[rd_ptr_q] : VADDR;
  assign MWDATA = data_mem[rd_ptr_q];

  // Full is judged on the registered count so WREADY never depends on VREQ.
  assign WREADY = !RST && !full;
  assign push   = WVALID && WREADY;
  assign pop    = MWE;

  assign VDATA  = MRDATA;
  assign VVALID = vvalid_q;
  assign COUNT  = count_q;
  assign STARVE = starve_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + Pw'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + Pw'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + Cw'(1);
      2'b01:   count_d = count_q - Cw'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_cond  = full && VREQ;
    starve_cnt_d = '0;
    if (starve_cond) begin
      starve_cnt_d = (starve_cnt_q == StarveMaxC) ? starve_cnt_q : starve_cnt_q + Sw'(1);
    end
    starve_set = starve_cond && (starve_cnt_d == StarveMaxC);
    // A fresh set condition outranks a clear issued in the same cycle.
    starve_d   = starve_set || (starve_q && !CLR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      vvalid_q     <= 1'b0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      vvalid_q     <= VREQ;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= WADDR;
      data_mem[wr_ptr_q] <= WDATA;
    end
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares the single-port framebuffer RAM between two requesters: VGA scanout (read, hard real-time) and a pixel writer (e.g. UART-driven drawing engine). Scanout always wins the port. Writes are queued in a small FIFO and drained into the RAM in any cycle scanout does not use the port, typically blanking. Sits between VGA/Delay timing logic, the writer, and the VRAM array in SoC.

Parameters:
Waddr, 19, framebuffer address width (640*480 < 2^19)
Wdata, 1, pixel width in bits
Depth, 4, write FIFO entries; power of two, at least 2
StarveMax, 1024, consecutive full-FIFO cycles before STARVE is raised

Ports:
CLK  in  1  system clock; all state changes on rising edge
RST  in  1  asynchronous, active-high reset
VREQ  in  1  scanout read request, one read per cycle while high
VADDR  in  Waddr  scanout read address
VDATA  out  Wdata  scanout read data (combinational pass-through of MRDATA)
VVALID  out  1  VDATA valid this cycle
WVALID  in  1  writer offers a pixel
WADDR  in  Waddr  writer pixel address
WDATA  in  Wdata  writer pixel value
WREADY  out  1  FIFO can accept; transfer when WVALID & WREADY
MADDR  out  Waddr  RAM address (combinational)
MWE  out  1  RAM write enable (combinational)
MWDATA  out  Wdata  RAM write data (combinational)
MRDATA  in  Wdata  RAM read data; synchronous RAM, valid the cycle after address
COUNT  out  $clog2(Depth)+1  FIFO occupancy
STARVE  out  1  sticky: writer starved by scanout
CLR  in  1  synchronous clear of STARVE

Behaviour:
- Reset (RST high, asynchronous):
  - FIFO emptied; read/write pointers = 0; COUNT = 0.
  - VVALID = 0, STARVE = 0, starve counter = 0.
  - WREADY and MWE forced to 0 while RST is high.
- Grant each cycle (combinational, fixed priority):
  - VREQ=1: read grant. MADDR=VADDR, MWE=0.
  - VREQ=0 and COUNT>0: write grant. MADDR/MWDATA = FIFO head, MWE=1, head popped at the edge.
  - Otherwise: idle. MWE=0, MADDR=VADDR, MWDATA=head value (don't care).
- Read latency: exactly 1 cycle.
  - VVALID is VREQ registered.
  - VDATA = MRDATA. When VVALID=0, VDATA is don't care.
- FIFO:
  - WREADY = !RST & (COUNT != Depth).
  - Push on WVALID & WREADY. Pop on write grant.
  - Simultaneous push and pop: COUNT unchanged, both pointers advance.
  - Pointers wrap modulo Depth.
  - No bypass. A pixel pushed into an empty FIFO reaches MWE no earlier than the next cycle.
  - When full, WREADY=0 even if a pop occurs that cycle. This is a registered-full policy, which keeps WREADY independent of VREQ.
  - Writes reach the RAM in push order.
- Hazard: a scanout read of an address with a queued write returns the old RAM contents. This is accepted; no forwarding.
- Starvation:
  - The counter increments each cycle with COUNT==Depth & VREQ; otherwise it resets to 0. It saturates at StarveMax.
  - STARVE is set on the cycle the counter reaches StarveMax and stays high until CLR or RST.
  - CLR and a set condition in the same cycle: set wins.
- Reset mid-operation: queued, unwritten pixels are discarded. A write granted on the same edge that RST asserts is not guaranteed.

Test Plan:
- Reset then idle (VREQ=0, WVALID=0) -> COUNT=0, WREADY=1, MWE=0, VVALID=0, STARVE=0.
- VREQ=1 VADDR=0x00010 for 3 cycles, RAM preloaded 1 at 0x00010 -> MWE=0 throughout, VVALID high cycles 2-4 with VDATA=1.
- VREQ=1 held; push 4 pixels (addr 0..3, data 1) -> COUNT=4, WREADY=0 after 4th push, MWE never 1. Then VREQ=0 -> MWE=1 on 4 consecutive cycles, addresses 0,1,2,3 in order, COUNT back to 0.
- COUNT=2, VREQ=0, WVALID=1 each cycle -> simultaneous push/pop, COUNT stays 2, RAM writes in push order.
- StarveMax=8, FIFO full, VREQ=1 for 8 cycles -> STARVE=1 on the 8th cycle. Pulse CLR with VREQ still high and FIFO still full -> STARVE stays 1. Drop VREQ, then pulse CLR -> STARVE=0.
- COUNT=3, assert RST mid-drain -> COUNT=0 and MWE=0 immediately (asynchronous); after release, no stale writes are issued.
